// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
package fetch_pkg;
  localparam int INSTR_W  = 32;
  localparam int PC_STEP  = 4;
  localparam int PC_W_MAX = 64;

  // Queue entry; pc is sized for the widest supported XLEN and zero-extended.
  typedef struct packed {
    logic [PC_W_MAX-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with occupancy count, flush and combinational head read.
module fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic [W-1:0]                   push_data,
  input  logic                           pop,
  output logic [W-1:0]                   head,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetcher: issues word fetches, tags them with their PC and
// queues returned instructions for decode; redirects flush and discard stale data.
module instruction_prefetch
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc
);
  localparam int             CW    = $clog2(DEPTH + 1);
  localparam int             QW    = $bits(fetch_entry_t);
  localparam logic [CW:0]    LIMIT = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   inflight;
  logic [CW:0]     occupancy;
  logic            req_fire;
  logic            rsp_accept;
  logic            rsp_keep;
  logic            q_pop;
  logic            q_empty;
  logic            q_full;
  logic            tag_empty;
  logic            tag_full;
  logic [XLEN-1:0] tag_pc;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  // Queue slots are reserved at request time, so a returning response always fits.
  assign occupancy      = {1'b0, q_count} + {1'b0, inflight};
  assign imem_req_valid = !rst && !redirect_valid && (occupancy < LIMIT);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready && !tag_full;
  assign rsp_accept     = imem_rsp_valid && !tag_empty;
  assign rsp_keep       = rsp_accept && !redirect_valid && (discard == '0) && !q_full;
  assign q_pop          = out_valid && out_ready;

  assign push_entry.pc    = PC_W_MAX'(tag_pc);
  assign push_entry.instr = imem_rsp_data;

  // The tag tracker holds one PC per outstanding request; its count is the inflight counter.
  fetch_fifo #(
    .W     (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_accept),
    .head      (tag_pc),
    .count     (inflight),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  fetch_fifo #(
    .W     (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (q_pop),
    .head      (head_entry),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  assign out_valid = !q_empty;
  assign out_instr = q_empty ? '0 : head_entry.instr;
  assign out_pc    = q_empty ? '0 : head_entry.pc[XLEN-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~XLEN'(3);
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + XLEN'(PC_STEP);
    end
  end

  // On redirect every request still outstanding after this cycle must be thrown away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard <= '0;
    end else if (redirect_valid) begin
      discard <= inflight + CW'(req_fire) - CW'(rsp_accept);
    end else if (rsp_accept && (discard != '0)) begin
      discard <= discard - CW'(1);
    end
  end
endmodule

// File: tb/tb_instruction_prefetch.sv
// Bench for instruction_prefetch: memory model, scoreboard, cycle table and corner sequences.
module tb_instruction_prefetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  logic        rsp_en;
  logic        junk;
  logic [63:0] mem_q[$];
  logic [95:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    logic        out_ready;
    logic        exp_rv;
    logic [63:0] exp_addr;
    logic        exp_ov;
    logic [63:0] exp_pc;
  } vec_t;
  vec_t vecs[12];

  instruction_prefetch #(
    .XLEN     (64),
    .DEPTH    (4),
    .RESET_PC (64'h1000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    out_ready = 1'b0;
    rsp_en = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Called at a negedge; advances until out_valid or the budget runs out.
  task automatic wait_out(input string name, input logic [63:0] exp_pc);
    for (int n = 0; n < 30; n++) begin
      step();
      @(negedge clk);
      if (out_valid) break;
    end
    chk({name, "_valid"}, {95'd0, out_valid}, 96'd1);
    chk({name, "_pc"}, {32'd0, out_pc}, {32'd0, exp_pc});
    chk({name, "_instr"}, {64'd0, out_instr}, {64'd0, instr_of(exp_pc)});
  endtask

  // Memory model: accepted request at edge N is answered at edge N+1 when rsp_en is set.
  initial begin
    logic        hs;
    logic [63:0] a;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      hs = imem_req_valid && imem_req_ready;
      a  = imem_req_addr;
      @(posedge clk);
      #1;
      if (rst) begin
        mem_q.delete();
        imem_rsp_valid = junk;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end else begin
        if (hs) mem_q.push_back(a);
        if (rsp_en && mem_q.size() > 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = instr_of(mem_q.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = '0;
        end
      end
    end
  end

  // Scoreboard: expect {pc, instr} per accepted request; a redirect or reset voids all.
  always @(negedge clk) begin
    logic [95:0] e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_extra: got pc %0h, expected no output", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", {32'd0, out_pc}, {32'd0, e[95:32]});
          chk("sb_instr", {64'd0, out_instr}, {64'd0, e[31:0]});
        end
      end
      if (redirect_valid) exp_q.delete();
      if (imem_req_valid && imem_req_ready)
        exp_q.push_back({imem_req_addr, instr_of(imem_req_addr)});
    end
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b0;
    out_ready = 1'b0;
    rsp_en = 1'b0;
    junk = 1'b0;

    // Cycle table after reset release: stall decode, then release it.
    vecs[0]  = '{1'b0, 1'b1, 64'h1000, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 1'b1, 64'h1004, 1'b0, 64'h0};
    vecs[2]  = '{1'b0, 1'b1, 64'h1008, 1'b1, 64'h1000};
    vecs[3]  = '{1'b0, 1'b1, 64'h100C, 1'b1, 64'h1000};
    vecs[4]  = '{1'b0, 1'b0, 64'h1010, 1'b1, 64'h1000};
    vecs[5]  = '{1'b0, 1'b0, 64'h1010, 1'b1, 64'h1000};
    vecs[6]  = '{1'b0, 1'b0, 64'h1010, 1'b1, 64'h1000};
    vecs[7]  = '{1'b1, 1'b0, 64'h1010, 1'b1, 64'h1000};
    vecs[8]  = '{1'b1, 1'b1, 64'h1010, 1'b1, 64'h1004};
    vecs[9]  = '{1'b1, 1'b1, 64'h1014, 1'b1, 64'h1008};
    vecs[10] = '{1'b1, 1'b1, 64'h1018, 1'b1, 64'h100C};
    vecs[11] = '{1'b1, 1'b1, 64'h101C, 1'b1, 64'h1010};

    step();
    step();
    @(negedge clk);
    chk("rst_out_valid", {95'd0, out_valid}, 96'd0);
    chk("rst_req_valid", {95'd0, imem_req_valid}, 96'd0);
    chk("rst_out_pc", {32'd0, out_pc}, 96'd0);
    chk("rst_out_instr", {64'd0, out_instr}, 96'd0);
    step();
    rst = 1'b0;
    rsp_en = 1'b1;
    imem_req_ready = 1'b1;

    for (int i = 0; i < 12; i++) begin
      out_ready = vecs[i].out_ready;
      @(negedge clk);
      chk($sformatf("vec%0d_req_valid", i), {95'd0, imem_req_valid}, {95'd0, vecs[i].exp_rv});
      chk($sformatf("vec%0d_req_addr", i), {32'd0, imem_req_addr}, {32'd0, vecs[i].exp_addr});
      chk($sformatf("vec%0d_out_valid", i), {95'd0, out_valid}, {95'd0, vecs[i].exp_ov});
      chk($sformatf("vec%0d_out_pc", i), {32'd0, out_pc}, {32'd0, vecs[i].exp_pc});
      if (!vecs[i].exp_ov)
        chk($sformatf("vec%0d_out_instr", i), {64'd0, out_instr}, 96'd0);
      step();
    end

    // Redirect with two requests outstanding.
    do_reset();
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h2002;
    @(negedge clk);
    chk("redir_req_blocked", {95'd0, imem_req_valid}, 96'd0);
    step();
    redirect_valid = 1'b0;
    rsp_en = 1'b1;
    @(negedge clk);
    chk("redir_req_valid", {95'd0, imem_req_valid}, 96'd1);
    chk("redir_req_addr", {32'd0, imem_req_addr}, {32'd0, 64'h2000});
    wait_out("redir_first", 64'h2000);

    // Back-to-back redirects with responses held, then one coincident with the second.
    step();
    step();
    rsp_en = 1'b0;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h3000;
    rsp_en = 1'b1;
    step();
    redirect_pc = 64'h4001;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("b2b_req_addr", {32'd0, imem_req_addr}, {32'd0, 64'h4000});
    wait_out("b2b_first", 64'h4000);

    // Memory stall keeps the address; a redirect replaces it.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_req_valid", i), {95'd0, imem_req_valid}, 96'd1);
      chk($sformatf("stall%0d_req_addr", i), {32'd0, imem_req_addr}, {32'd0, 64'h1000});
      step();
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'h5000;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("stall_redir_addr", {32'd0, imem_req_addr}, {32'd0, 64'h5000});

    // Address wrap at the top of the PC space.
    step();
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    rsp_en = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("wrap_addr_top", {32'd0, imem_req_addr}, {32'd0, 64'hFFFF_FFFF_FFFF_FFFC});
    step();
    @(negedge clk);
    chk("wrap_addr_zero", {32'd0, imem_req_addr}, 96'd0);
    for (int i = 0; i < 4; i++) step();

    // Reset while data is queued and requests are outstanding.
    do_reset();
    imem_req_ready = 1'b1;
    rsp_en = 1'b1;
    step();
    step();
    rsp_en = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("pre_rst_out_valid", {95'd0, out_valid}, 96'd1);
    chk("pre_rst_req_valid", {95'd0, imem_req_valid}, 96'd0);
    #1;
    rst = 1'b1;
    junk = 1'b1;
    #1;
    chk("mid_rst_out_valid", {95'd0, out_valid}, 96'd0);
    chk("mid_rst_req_valid", {95'd0, imem_req_valid}, 96'd0);
    chk("mid_rst_out_pc", {32'd0, out_pc}, 96'd0);
    step();
    step();
    junk = 1'b0;
    step();
    rst = 1'b0;
    rsp_en = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("restart_req_valid", {95'd0, imem_req_valid}, 96'd1);
    chk("restart_req_addr", {32'd0, imem_req_addr}, {32'd0, 64'h1000});
    wait_out("restart_first", 64'h1000);

    // Stop fetching and drain everything that is outstanding.
    step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    @(negedge clk);
    chk("drain_exp_q", {64'd0, 32'(exp_q.size())}, 96'd0);
    chk("drain_out_valid", {95'd0, out_valid}, 96'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
